// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine: issue FSM states and the mode-bit layout.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_C     = 3'd1,
        S_RD_AB    = 3'd2,
        S_WAIT_ACC = 3'd3,
        S_WR_C     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    typedef struct packed {
        logic sgn;  // operands and seed are two's complement
        logic bt;   // B held transposed in memory
        logic acc;  // accumulate onto existing C
    } mode_t;

endpackage

// File: rtl/matmul_mac.sv
// Pairs returned read beats (optional C seed, then A/B) and accumulates the products for one C element.
// Captures one beat per cycle with no backpressure; results are valid once o_seed_ok and o_pairs reach K.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int MEM_DW   = 32,
    parameter int PREC     = 16,
    parameter int ACC_W    = 40,
    parameter int DIM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_seed,
    input  logic                i_sgn,
    input  logic                i_active,
    input  logic                i_rdata_vld,
    input  logic [MEM_DW-1:0]   i_rdata,
    output logic                o_seed_ok,
    output logic [DIM_BITS-1:0] o_pairs,
    output logic [MEM_DW-1:0]   o_wdata
);

    logic [ACC_W-1:0]      r_acc;
    logic [PREC-1:0]       r_a_op;
    logic [DIM_BITS-1:0]   r_pairs;
    logic                  r_need_seed;
    logic                  r_beat_b;

    logic signed [PREC:0]     w_a_ext;
    logic signed [PREC:0]     w_b_ext;
    logic signed [2*PREC+1:0] w_prod;
    logic signed [MEM_DW:0]   w_seed_ext;
    logic [ACC_W-1:0]         w_prod_acc;
    logic [ACC_W-1:0]         w_seed;

    // One extra bit per operand lets a single signed multiplier serve both modes.
    assign w_a_ext    = {i_sgn & r_a_op[PREC-1], r_a_op};
    assign w_b_ext    = {i_sgn & i_rdata[PREC-1], i_rdata[PREC-1:0]};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_acc = ACC_W'(w_prod);
    assign w_seed_ext = {i_sgn & i_rdata[MEM_DW-1], i_rdata};
    assign w_seed     = ACC_W'(w_seed_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_a_op      <= '0;
            r_pairs     <= '0;
            r_need_seed <= 1'b0;
            r_beat_b    <= 1'b0;
        end else if (i_clr) begin
            r_acc       <= '0;
            r_pairs     <= '0;
            r_need_seed <= i_seed;
            r_beat_b    <= 1'b0;
        end else if (i_active && i_rdata_vld) begin
            if (r_need_seed) begin
                r_acc       <= w_seed;
                r_need_seed <= 1'b0;
            end else if (!r_beat_b) begin
                r_a_op   <= i_rdata[PREC-1:0];
                r_beat_b <= 1'b1;
            end else begin
                r_acc    <= r_acc + w_prod_acc;
                r_pairs  <= r_pairs + DIM_BITS'(1);
                r_beat_b <= 1'b0;
            end
        end
    end

    assign o_seed_ok = !r_need_seed && !r_beat_b;
    assign o_pairs   = r_pairs;

    generate
        if (ACC_W >= MEM_DW) begin : g_wd_trunc
            assign o_wdata = r_acc[MEM_DW-1:0];
        end else begin : g_wd_zext
            assign o_wdata = {{(MEM_DW-ACC_W){1'b0}}, r_acc};
        end
    endgenerate

endmodule

// File: rtl/matmul_gen.sv
// Memory-driven C = [C +] A*B engine: issue FSM and incremental address generation around matmul_mac.
// One request in flight at the interface; a request holds until granted, sm_ena low stalls new issue only.
module matmul_gen
    import matmul_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DIM_BITS = 16,
    parameter int PREC     = 16,
    parameter int ACC_W    = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                sm_ena,
    input  logic                mode_signed,
    input  logic                mode_bt,
    input  logic                mode_acc,
    input  logic [MEM_AW-1:0]   aBASE,
    input  logic [MEM_AW-1:0]   bBASE,
    input  logic [MEM_AW-1:0]   cBASE,
    input  logic [DIM_BITS-1:0] aSTRIDE,
    input  logic [DIM_BITS-1:0] bSTRIDE,
    input  logic [DIM_BITS-1:0] cSTRIDE,
    input  logic [DIM_BITS-1:0] dimM,
    input  logic [DIM_BITS-1:0] dimN,
    input  logic [DIM_BITS-1:0] dimK,
    output logic                mem_req,
    output logic                mem_write,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rdata_vld,
    input  logic [MEM_DW-1:0]   mem_rdata,
    output logic                busy,
    output logic                done
);

    state_t                r_state, w_state_nxt;
    mode_t                 r_mode;
    logic [DIM_BITS-1:0]   r_dim_m, r_dim_n, r_dim_k;
    logic [DIM_BITS-1:0]   r_i, r_j, r_k;
    logic [MEM_AW-1:0]     r_a_stride, r_b_stride, r_c_stride, r_b_base;
    logic [MEM_AW-1:0]     r_a_row, r_a_addr, r_b_col, r_b_addr, r_c_row, r_c_addr;
    logic                  r_sel_b, r_pend, r_zero;

    logic                  w_want, w_wr, w_gnt, w_start, w_clr, w_seed_ok, w_mac_done;
    logic                  w_last_i, w_last_j, w_last_k;
    logic [MEM_AW-1:0]     w_addr, w_b_kstep, w_b_jstep;
    logic [DIM_BITS-1:0]   w_pairs;
    logic [MEM_DW-1:0]     w_wdata;

    assign w_start    = (r_state == S_IDLE) && go && sm_ena;
    assign w_gnt      = mem_req && mem_gnt;
    assign w_last_i   = (r_i == r_dim_m - DIM_BITS'(1));
    assign w_last_j   = (r_j == r_dim_n - DIM_BITS'(1));
    assign w_last_k   = (r_k == r_dim_k - DIM_BITS'(1));
    assign w_b_kstep  = r_mode.bt ? MEM_AW'(1) : r_b_stride;
    assign w_b_jstep  = r_mode.bt ? r_b_stride : MEM_AW'(1);
    assign w_mac_done = w_seed_ok && (w_pairs == r_dim_k);
    assign w_clr      = w_start || (w_gnt && (r_state == S_WR_C));

    // Request content depends only on registered state so it stays put while stalled.
    always_comb begin
        w_want = 1'b0;
        w_wr   = 1'b0;
        w_addr = '0;
        case (r_state)
            S_RD_C: begin
                w_want = !r_zero && r_mode.acc;
                w_addr = r_c_addr;
            end
            S_RD_AB: begin
                w_want = (r_dim_k != '0);
                w_addr = r_sel_b ? r_b_addr : r_a_addr;
            end
            S_WR_C: begin
                w_want = 1'b1;
                w_wr   = 1'b1;
                w_addr = r_c_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_state_nxt = S_RD_C;
            S_RD_C: begin
                if (r_zero)             w_state_nxt = S_DONE;
                else if (!r_mode.acc)   w_state_nxt = S_RD_AB;
                else if (w_gnt)         w_state_nxt = S_RD_AB;
            end
            S_RD_AB: begin
                if (r_dim_k == '0)                  w_state_nxt = S_WAIT_ACC;
                else if (w_gnt && r_sel_b && w_last_k) w_state_nxt = S_WAIT_ACC;
            end
            S_WAIT_ACC: if (w_mac_done) w_state_nxt = S_WR_C;
            S_WR_C: begin
                if (w_gnt) begin
                    if (w_last_i && w_last_j) w_state_nxt = S_DONE;
                    else                      w_state_nxt = r_mode.acc ? S_RD_C : S_RD_AB;
                end
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (!sm_ena && !w_gnt) w_state_nxt = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= '0;
            r_dim_m    <= '0;
            r_dim_n    <= '0;
            r_dim_k    <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_a_stride <= '0;
            r_b_stride <= '0;
            r_c_stride <= '0;
            r_b_base   <= '0;
            r_a_row    <= '0;
            r_a_addr   <= '0;
            r_b_col    <= '0;
            r_b_addr   <= '0;
            r_c_row    <= '0;
            r_c_addr   <= '0;
            r_sel_b    <= 1'b0;
            r_pend     <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_pend <= mem_req && !mem_gnt;
            if (w_start) begin
                r_mode     <= '{sgn: mode_signed, bt: mode_bt, acc: mode_acc};
                r_dim_m    <= dimM;
                r_dim_n    <= dimN;
                r_dim_k    <= dimK;
                r_zero     <= (dimM == '0) || (dimN == '0);
                r_a_stride <= MEM_AW'(aSTRIDE);
                r_b_stride <= MEM_AW'(bSTRIDE);
                r_c_stride <= MEM_AW'(cSTRIDE);
                r_b_base   <= bBASE;
                r_a_row    <= aBASE;
                r_a_addr   <= aBASE;
                r_b_col    <= bBASE;
                r_b_addr   <= bBASE;
                r_c_row    <= cBASE;
                r_c_addr   <= cBASE;
                r_i        <= '0;
                r_j        <= '0;
                r_k        <= '0;
                r_sel_b    <= 1'b0;
            end
            if (w_gnt && (r_state == S_RD_AB)) begin
                r_sel_b <= !r_sel_b;
                if (r_sel_b) begin
                    r_k      <= r_k + DIM_BITS'(1);
                    r_a_addr <= r_a_addr + MEM_AW'(1);
                    r_b_addr <= r_b_addr + w_b_kstep;
                end
            end
            // Step to the next C element: j inner, i outer; A/B pointers rewind to row/column starts.
            if (w_gnt && (r_state == S_WR_C)) begin
                r_k     <= '0;
                r_sel_b <= 1'b0;
                if (w_last_j) begin
                    r_j      <= '0;
                    r_i      <= r_i + DIM_BITS'(1);
                    r_a_row  <= r_a_row + r_a_stride;
                    r_a_addr <= r_a_row + r_a_stride;
                    r_c_row  <= r_c_row + r_c_stride;
                    r_c_addr <= r_c_row + r_c_stride;
                    r_b_col  <= r_b_base;
                    r_b_addr <= r_b_base;
                end else begin
                    r_j      <= r_j + DIM_BITS'(1);
                    r_a_addr <= r_a_row;
                    r_c_addr <= r_c_addr + MEM_AW'(1);
                    r_b_col  <= r_b_col + w_b_jstep;
                    r_b_addr <= r_b_col + w_b_jstep;
                end
            end
        end
    end

    matmul_mac #(
        .MEM_DW   (MEM_DW),
        .PREC     (PREC),
        .ACC_W    (ACC_W),
        .DIM_BITS (DIM_BITS)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_seed      (w_start ? mode_acc : r_mode.acc),
        .i_sgn       (r_mode.sgn),
        .i_active    (r_state != S_IDLE),
        .i_rdata_vld (mem_rdata_vld),
        .i_rdata     (mem_rdata),
        .o_seed_ok   (w_seed_ok),
        .o_pairs     (w_pairs),
        .o_wdata     (w_wdata)
    );

    assign mem_req   = w_want && (sm_ena || r_pend);
    assign mem_write = mem_req && w_wr;
    assign mem_addr  = mem_req ? w_addr : '0;
    assign mem_wdata = (mem_req && w_wr) ? w_wdata : '0;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);

endmodule

// File: doc/matmul_gen.md
MATMUL_GEN -- requirements
Module: matmul_gen

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, memory word-address width.
REQ-002 SHALL have parameter MEM_DW, default 32, memory data width.
REQ-003 SHALL have parameter DIM_BITS, default 16, width of dimension and stride inputs.
REQ-004 SHALL have parameter PREC, default 16, operand width taken from the low bits of each read word.
REQ-005 SHALL have parameter ACC_W, default 40, accumulator width (ACC_W >= 2*PREC).
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start pulse, sampled only in IDLE.
- sm_ena  in  1  issue-side enable; low freezes the issue FSM.
- mode_signed  in  1  operands signed when 1.
- mode_bt  in  1  B stored transposed when 1.
- mode_acc  in  1  C = C + A*B when 1, else C = A*B.
- aBASE, bBASE, cBASE  in  MEM_AW each  matrix base word addresses.
- aSTRIDE, bSTRIDE, cSTRIDE  in  DIM_BITS each  row pitches in words.
- dimM, dimN, dimK  in  DIM_BITS each  A is MxK, B is KxN, C is MxN.
- mem_req  out  1  request valid.
- mem_write  out  1  1 = write, 0 = read.
- mem_addr  out  MEM_AW  request address.
- mem_wdata  out  MEM_DW  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata_vld  in  1  read data valid; returns in request order, latency >= 1.
- mem_rdata  in  MEM_DW  read data.
- busy  out  1  high from the cycle after go is accepted until done.
- done  out  1  one-cycle pulse after the last C write is granted.

Function
REQ-007 SHALL latch modes, bases, strides and dimensions on go accepted in IDLE; go while busy SHALL be ignored.
REQ-008 SHALL use addresses A(i,k)=aBASE+i*aSTRIDE+k, C(i,j)=cBASE+i*cSTRIDE+j, B(k,j)=bBASE+k*bSTRIDE+j (mode_bt=0) or bBASE+j*bSTRIDE+k (mode_bt=1), computed incrementally, modulo 2^MEM_AW.
REQ-009 SHALL use issue FSM states IDLE, RD_C, RD_AB, WAIT_ACC, WR_C, DONE; loop order i outer, j middle, k inner.
REQ-010 Per (i,j): RD_C (only if mode_acc) issues one read of C(i,j); RD_AB issues A(i,k) then B(k,j) for k=0..K-1; WAIT_ACC waits until all K pairs are accumulated; WR_C issues one write of C(i,j).
REQ-011 mem_req with mem_addr, mem_write and mem_wdata SHALL stay stable until the cycle mem_gnt=1; the next request MAY be presented the following cycle.
REQ-012 With sm_ena=0 the FSM SHALL hold state and issue no new request; a pending request SHALL remain asserted until granted; read-data capture SHALL continue.
REQ-013 The datapath SHALL seed the accumulator with sign/zero-extended C(i,j) (mode_acc=1) or 0, then add the product of each returned A/B pair (first beat A, second beat B) of PREC-bit operands, signed or unsigned per mode_signed.
REQ-014 The accumulator SHALL wrap modulo 2^ACC_W; mem_wdata SHALL be its low MEM_DW bits, zero-extended when ACC_W < MEM_DW.
REQ-015 If dimM=0 or dimN=0, SHALL issue no memory traffic and pulse done 2 cycles after go.
REQ-016 If dimK=0, SHALL write each C(i,j) with 0 (mode_acc=0) or its read value (mode_acc=1).
REQ-017 DONE SHALL last one cycle, asserting done and returning to IDLE; busy SHALL drop in the same cycle done is high.
REQ-018 Outstanding reads SHALL never exceed 2*K+1; read data arriving while IDLE SHALL be discarded.

Reset
REQ-019 rst SHALL immediately force IDLE and set mem_req, mem_write, busy, done, mem_addr, mem_wdata, accumulator and all counters to 0.
REQ-020 Reset mid-operation SHALL abandon the job with no further requests; the next go SHALL start cleanly.

Structure
REQ-021 FSM state encoding and the mode-bit field layout SHALL reside in shared package matmul_pkg.
REQ-022 The multiply-accumulate datapath (beat pairing, seed, MAC, pair counter) SHALL be sub-module matmul_mac; matmul_gen holds the issue FSM and address generation.

Verification
REQ-023 M=N=K=2, unsigned, A=[1,2;3,4], B=[5,6;7,8] -> C=[19,22;43,50], 4 writes, exactly one done pulse.
REQ-024 M=N=K=1, mode_signed=1, A=0xFFFF, B=3 -> C word 0xFFFFFFFD.
REQ-025 mode_acc=1, C preloaded 100, A=[2,3] (1x2), B=[4;5] -> C=123.
REQ-026 REQ-023 data with B stored transposed and mode_bt=1 -> identical C.
REQ-027 dimM=0 -> no mem_req, done 2 cycles after go; dimK=0, mode_acc=0 -> all C words 0.
REQ-028 Random mem_gnt stalls, read latency 1..8, sm_ena toggling, rst pulse mid-job -> outputs 0 during reset, no requests afterwards, rerun of REQ-023 correct.
